// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM input in clkin cycles,
// one sample per frame, with a timeout sample when the input stops toggling.
module pwm_capture #(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 2 * (2 ** CNT_W),
   parameter int unsigned PER_W       = $clog2(TIMEOUT) + 1
) (
   input  logic             clkin,
   input  logic             reset_n,
   input  logic             pwm_in,
   output logic [PER_W-1:0] high_out,
   output logic [PER_W-1:0] period_out,
   output logic             sample_valid,
   output logic             no_edge,
   output logic             level_out
);

   localparam logic [PER_W-1:0] CNT_SAT = PER_W'(TIMEOUT);
   localparam logic [PER_W-1:0] CNT_ARM = PER_W'(TIMEOUT - 1);
   localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   s_c;
   logic                   rise_c;
   logic [PER_W-1:0]       per_cnt;
   logic [PER_W-1:0]       hi_cnt;
   state_t                 state_q;
   state_t                 state_d;
   logic                   pub_meas_c;
   logic                   pub_to_c;

   assign s_c    = sync_q[SYNC_STAGES-1];
   assign rise_c = s_c & ~prev_q;

   // Synchroniser chain plus one delay flop for rising-edge detection
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         prev_q <= s_c;
      end
   end

   // Period and high-time counters, restarted on every rising edge, saturating at TIMEOUT
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise_c) begin
         per_cnt <= CNT_ONE;
         hi_cnt  <= CNT_ONE;
      end else begin
         if (per_cnt != CNT_SAT) begin
            per_cnt <= per_cnt + CNT_ONE;
         end
         if (s_c && (hi_cnt != CNT_SAT)) begin
            hi_cnt <= hi_cnt + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A rise always wins over the timeout; the timeout fires once because per_cnt saturates past it
   always_comb begin
      state_d    = state_q;
      pub_meas_c = 1'b0;
      pub_to_c   = 1'b0;
      if (rise_c) begin
         state_d    = MEASURE;
         pub_meas_c = (state_q == MEASURE);
      end else if (per_cnt == CNT_ARM) begin
         state_d  = IDLE;
         pub_to_c = 1'b1;
      end
   end

   // Published sample registers
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         high_out     <= '0;
         period_out   <= '0;
         sample_valid <= 1'b0;
         no_edge      <= 1'b0;
         level_out    <= 1'b0;
      end else begin
         sample_valid <= pub_meas_c | pub_to_c;
         if (pub_meas_c) begin
            high_out   <= hi_cnt;
            period_out <= per_cnt;
            no_edge    <= 1'b0;
            level_out  <= 1'b0;
         end else if (pub_to_c) begin
            high_out   <= '0;
            period_out <= '0;
            no_edge    <= 1'b1;
            level_out  <= s_c;
         end
      end
   end

endmodule
